// File: rtl/ex_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM/WB register usage in, pipeline hold/clear
// controls and operand-forward selects out.
interface ex_hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PERF_WIDTH     = 32
);
  logic [REG_ADDR_WIDTH-1:0] id_rs1_i;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_i;
  logic                      id_use_rs1_i;
  logic                      id_use_rs2_i;
  logic [REG_ADDR_WIDTH-1:0] ex_dest_i;
  logic                      ex_reg_write_i;
  logic                      ex_mem_read_i;
  logic                      ex_mc_i;
  logic [REG_ADDR_WIDTH-1:0] mem_dest_i;
  logic                      mem_reg_write_i;
  logic [REG_ADDR_WIDTH-1:0] wb_dest_i;
  logic                      wb_reg_write_i;
  logic                      branch_taken_i;

  logic [1:0]                fwd_a_o;
  logic [1:0]                fwd_b_o;
  logic                      stall_if_o;
  logic                      stall_id_o;
  logic                      bubble_ex_o;
  logic                      stall_ex_o;
  logic                      bubble_mem_o;
  logic                      flush_o;
  logic                      pc_redirect_o;
  logic                      mc_busy_o;
  logic [PERF_WIDTH-1:0]     perf_stall_cnt_o;

  // Pipeline side: supplies stage info, consumes controls.
  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           ex_dest_i, ex_reg_write_i, ex_mem_read_i, ex_mc_i,
           mem_dest_i, mem_reg_write_i, wb_dest_i, wb_reg_write_i,
           branch_taken_i,
    input  fwd_a_o, fwd_b_o, stall_if_o, stall_id_o, bubble_ex_o,
           stall_ex_o, bubble_mem_o, flush_o, pc_redirect_o, mc_busy_o,
           perf_stall_cnt_o
  );

  // Hazard controller side.
  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           ex_dest_i, ex_reg_write_i, ex_mem_read_i, ex_mc_i,
           mem_dest_i, mem_reg_write_i, wb_dest_i, wb_reg_write_i,
           branch_taken_i,
    output fwd_a_o, fwd_b_o, stall_if_o, stall_id_o, bubble_ex_o,
           stall_ex_o, bubble_mem_o, flush_o, pc_redirect_o, mc_busy_o,
           perf_stall_cnt_o
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: operand forwarding, load-use bubble, multi-cycle
// EX occupancy FSM and taken-branch flush, plus a stall-cycle counter.
module ex_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MC_LATENCY     = 4,
  parameter int PERF_WIDTH     = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  ex_hazard_ctrl_if.slave hz
);
  localparam int CNT_W = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_BUSY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PERF_WIDTH-1:0] perf_q, perf_d;
  logic                  mc_busy_q, mc_busy_d;

  logic [1:0][REG_ADDR_WIDTH-1:0] id_rs;
  logic [1:0]                     id_use;
  logic [1:0]                     ex_hit, mem_hit, wb_hit;
  logic [1:0][1:0]                fwd_sel;
  logic                           load_use;

  logic stall_if, stall_id, bubble_ex, stall_ex, bubble_mem, flush, redirect;

  assign id_rs[0]  = hz.id_rs1_i;
  assign id_rs[1]  = hz.id_rs2_i;
  assign id_use[0] = hz.id_use_rs1_i;
  assign id_use[1] = hz.id_use_rs2_i;

  // Per-operand forwarding; the youngest producer (EX) wins.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic live;
    assign live        = id_use[gi] && (id_rs[gi] != '0);
    assign ex_hit[gi]  = live && hz.ex_reg_write_i  && (id_rs[gi] == hz.ex_dest_i);
    assign mem_hit[gi] = live && hz.mem_reg_write_i && (id_rs[gi] == hz.mem_dest_i);
    assign wb_hit[gi]  = live && hz.wb_reg_write_i  && (id_rs[gi] == hz.wb_dest_i);
    assign fwd_sel[gi] = ex_hit[gi]  ? 2'd1 :
                         mem_hit[gi] ? 2'd2 :
                         wb_hit[gi]  ? 2'd3 : 2'd0;
  end

  // ex_hit already implies a non-zero matching dest with reg_write set.
  assign load_use = (state_q == ST_RUN) && hz.ex_mem_read_i && (|ex_hit);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    bubble_ex  = 1'b0;
    stall_ex   = 1'b0;
    bubble_mem = 1'b0;
    flush      = 1'b0;
    redirect   = 1'b0;

    if (hz.branch_taken_i) begin
      // Anything in EX is younger than the branch, so abort it outright.
      flush    = 1'b1;
      redirect = 1'b1;
      state_d  = ST_RUN;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hz.ex_mc_i) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            bubble_mem = 1'b1;
            cnt_d      = CNT_W'(MC_LATENCY - 2);
            state_d    = ST_MC_BUSY;
          end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        ST_MC_BUSY: begin
          if (cnt_q != '0) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            bubble_mem = 1'b1;
            cnt_d      = cnt_q - CNT_W'(1);
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end

    mc_busy_d = (state_d == ST_MC_BUSY);
    perf_d    = (stall_if && !rst_i) ? perf_q + PERF_WIDTH'(1) : perf_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      perf_q    <= '0;
      mc_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      perf_q    <= perf_d;
      mc_busy_q <= mc_busy_d;
    end
  end

  // Reset masks every control combinationally, independent of flop state.
  assign hz.fwd_a_o          = rst_i ? 2'd0 : fwd_sel[0];
  assign hz.fwd_b_o          = rst_i ? 2'd0 : fwd_sel[1];
  assign hz.stall_if_o       = stall_if   && !rst_i;
  assign hz.stall_id_o       = stall_id   && !rst_i;
  assign hz.bubble_ex_o      = bubble_ex  && !rst_i;
  assign hz.stall_ex_o       = stall_ex   && !rst_i;
  assign hz.bubble_mem_o     = bubble_mem && !rst_i;
  assign hz.flush_o          = flush      && !rst_i;
  assign hz.pc_redirect_o    = redirect   && !rst_i;
  assign hz.mc_busy_o        = mc_busy_q  && !rst_i;
  assign hz.perf_stall_cnt_o = perf_q;
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: forwarding priority, load-use, multi-cycle
// occupancy, branch abort and reset behaviour, with hand-computed expectations.
module tb_ex_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .PERF_WIDTH(32)) hz ();

  ex_hazard_ctrl #(
    .REG_ADDR_WIDTH(5),
    .MC_LATENCY    (4),
    .PERF_WIDTH    (32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .hz   (hz)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic clear_inputs();
    hz.id_rs1_i        = '0;
    hz.id_rs2_i        = '0;
    hz.id_use_rs1_i    = 1'b0;
    hz.id_use_rs2_i    = 1'b0;
    hz.ex_dest_i       = '0;
    hz.ex_reg_write_i  = 1'b0;
    hz.ex_mem_read_i   = 1'b0;
    hz.ex_mc_i         = 1'b0;
    hz.mem_dest_i      = '0;
    hz.mem_reg_write_i = 1'b0;
    hz.wb_dest_i       = '0;
    hz.wb_reg_write_i  = 1'b0;
    hz.branch_taken_i  = 1'b0;
  endtask

  // Inputs are driven just after posedge; outputs sampled at the following negedge.
  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stalls(input string tag, input logic [3:0] exp);
    check_eq({tag, ".stall_if"},   hz.stall_if_o,   exp[3]);
    check_eq({tag, ".stall_id"},   hz.stall_id_o,   exp[2]);
    check_eq({tag, ".stall_ex"},   hz.stall_ex_o,   exp[1]);
    check_eq({tag, ".bubble_mem"}, hz.bubble_mem_o, exp[0]);
  endtask

  task automatic load_use_rs2_7();
    hz.ex_dest_i      = 5'd7;
    hz.ex_reg_write_i = 1'b1;
    hz.ex_mem_read_i  = 1'b1;
    hz.id_rs2_i       = 5'd7;
    hz.id_use_rs2_i   = 1'b1;
  endtask

  initial begin
    clear_inputs();
    // Reset: make forwarding and mc inputs active to prove the combinational mask.
    rst = 1'b1;
    hz.id_rs1_i = 5'd5; hz.id_use_rs1_i = 1'b1;
    hz.ex_dest_i = 5'd5; hz.ex_reg_write_i = 1'b1; hz.ex_mc_i = 1'b1;
    to_sample();
    check_eq("rst.fwd_a", hz.fwd_a_o, 2'd0);
    check_stalls("rst", 4'b0000);
    check_eq("rst.mc_busy", hz.mc_busy_o, 1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    to_sample();
    check_eq("rst.perf", hz.perf_stall_cnt_o, 32'd0);

    // Forwarding priority EX > MEM > WB.
    next_cycle();
    hz.id_rs1_i = 5'd5; hz.id_rs2_i = 5'd5;
    hz.id_use_rs1_i = 1'b1; hz.id_use_rs2_i = 1'b1;
    hz.ex_dest_i = 5'd5;  hz.ex_reg_write_i = 1'b1;
    hz.mem_dest_i = 5'd5; hz.mem_reg_write_i = 1'b1;
    hz.wb_dest_i = 5'd5;  hz.wb_reg_write_i = 1'b1;
    to_sample();
    check_eq("fwd.ex.a", hz.fwd_a_o, 2'd1);
    check_eq("fwd.ex.b", hz.fwd_b_o, 2'd1);
    check_eq("fwd.ex.stall", hz.stall_if_o, 1'b0);
    hz.ex_reg_write_i = 1'b0;
    #1;
    check_eq("fwd.mem.a", hz.fwd_a_o, 2'd2);
    check_eq("fwd.mem.b", hz.fwd_b_o, 2'd2);
    hz.mem_reg_write_i = 1'b0;
    #1;
    check_eq("fwd.wb.a", hz.fwd_a_o, 2'd3);
    check_eq("fwd.wb.b", hz.fwd_b_o, 2'd3);
    hz.id_use_rs1_i = 1'b0;
    #1;
    check_eq("fwd.nouse.a", hz.fwd_a_o, 2'd0);
    check_eq("fwd.nouse.b", hz.fwd_b_o, 2'd3);
    hz.id_use_rs1_i = 1'b1;
    hz.id_rs1_i = 5'd0; hz.ex_dest_i = 5'd0; hz.mem_dest_i = 5'd0; hz.wb_dest_i = 5'd0;
    hz.ex_reg_write_i = 1'b1; hz.mem_reg_write_i = 1'b1;
    #1;
    check_eq("fwd.x0.a", hz.fwd_a_o, 2'd0);

    // Load-use: one bubble, then MEM forwarding.
    next_cycle();
    clear_inputs();
    load_use_rs2_7();
    to_sample();
    check_eq("lu.stall_if",  hz.stall_if_o,  1'b1);
    check_eq("lu.stall_id",  hz.stall_id_o,  1'b1);
    check_eq("lu.bubble_ex", hz.bubble_ex_o, 1'b1);
    check_eq("lu.stall_ex",  hz.stall_ex_o,  1'b0);
    check_eq("lu.fwd_b",     hz.fwd_b_o,     2'd1);
    next_cycle();
    clear_inputs();
    hz.id_rs2_i = 5'd7; hz.id_use_rs2_i = 1'b1;
    hz.mem_dest_i = 5'd7; hz.mem_reg_write_i = 1'b1;
    to_sample();
    check_eq("lu2.fwd_b",    hz.fwd_b_o,    2'd2);
    check_eq("lu2.stall_if", hz.stall_if_o, 1'b0);
    check_eq("lu2.perf",     hz.perf_stall_cnt_o, 32'd1);

    // Multi-cycle op, MC_LATENCY=4: three stall cycles, busy on cycles 2-4.
    next_cycle();
    clear_inputs();
    hz.ex_mc_i = 1'b1;
    to_sample();
    check_stalls("mc1", 4'b1111);
    check_eq("mc1.busy", hz.mc_busy_o, 1'b0);
    next_cycle();
    to_sample();
    check_stalls("mc2", 4'b1111);
    check_eq("mc2.busy", hz.mc_busy_o, 1'b1);
    next_cycle();
    to_sample();
    check_stalls("mc3", 4'b1111);
    check_eq("mc3.busy", hz.mc_busy_o, 1'b1);
    next_cycle();
    load_use_rs2_7();
    to_sample();
    check_stalls("mc4", 4'b0000);
    check_eq("mc4.busy", hz.mc_busy_o, 1'b1);
    check_eq("mc4.bubble_ex", hz.bubble_ex_o, 1'b0);
    next_cycle();
    clear_inputs();
    to_sample();
    check_eq("mc5.busy", hz.mc_busy_o, 1'b0);
    check_eq("mc5.perf", hz.perf_stall_cnt_o, 32'd4);

    // Branch while MC_BUSY with cnt=1 aborts the op.
    next_cycle();
    hz.ex_mc_i = 1'b1;
    next_cycle();
    next_cycle();
    hz.branch_taken_i = 1'b1;
    to_sample();
    check_eq("brmc.flush",    hz.flush_o,       1'b1);
    check_eq("brmc.redirect", hz.pc_redirect_o, 1'b1);
    check_stalls("brmc", 4'b0000);
    check_eq("brmc.busy", hz.mc_busy_o, 1'b1);
    next_cycle();
    clear_inputs();
    to_sample();
    check_eq("brmc2.busy",  hz.mc_busy_o, 1'b0);
    check_eq("brmc2.flush", hz.flush_o,   1'b0);
    check_eq("brmc2.perf",  hz.perf_stall_cnt_o, 32'd6);

    // Branch beats a load-use match and a fresh multi-cycle op.
    next_cycle();
    load_use_rs2_7();
    hz.branch_taken_i = 1'b1;
    to_sample();
    check_eq("brlu.flush",     hz.flush_o,     1'b1);
    check_eq("brlu.bubble_ex", hz.bubble_ex_o, 1'b0);
    check_eq("brlu.stall_if",  hz.stall_if_o,  1'b0);
    next_cycle();
    clear_inputs();
    hz.ex_mc_i = 1'b1;
    hz.branch_taken_i = 1'b1;
    to_sample();
    check_eq("brmcr.flush", hz.flush_o, 1'b1);
    check_stalls("brmcr", 4'b0000);
    next_cycle();
    clear_inputs();
    to_sample();
    check_eq("brmcr2.busy", hz.mc_busy_o, 1'b0);
    check_eq("brmcr2.perf", hz.perf_stall_cnt_o, 32'd6);

    // Reset asserted on MC_BUSY cycle 2.
    next_cycle();
    hz.ex_mc_i = 1'b1;
    next_cycle();
    to_sample();
    check_eq("rmc.pre_busy", hz.mc_busy_o, 1'b1);
    check_eq("rmc.pre_perf", hz.perf_stall_cnt_o, 32'd7);
    rst = 1'b1;
    #1;
    check_stalls("rmc.rst", 4'b0000);
    check_eq("rmc.rst.busy", hz.mc_busy_o, 1'b0);
    check_eq("rmc.rst.flush", hz.flush_o, 1'b0);
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    to_sample();
    check_eq("rmc.post_busy", hz.mc_busy_o, 1'b0);
    check_eq("rmc.post_perf", hz.perf_stall_cnt_o, 32'd0);
    next_cycle();
    hz.ex_mc_i = 1'b1;
    to_sample();
    check_stalls("rmc.mc1", 4'b1111);
    next_cycle();
    to_sample();
    check_stalls("rmc.mc2", 4'b1111);
    next_cycle();
    to_sample();
    check_stalls("rmc.mc3", 4'b1111);
    next_cycle();
    to_sample();
    check_stalls("rmc.mc4", 4'b0000);
    check_eq("rmc.mc4.busy", hz.mc_busy_o, 1'b1);
    next_cycle();
    clear_inputs();
    to_sample();
    check_eq("rmc.mc5.busy", hz.mc_busy_o, 1'b0);
    check_eq("rmc.mc5.perf", hz.perf_stall_cnt_o, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
